// File: rtl/demux7to14.sv
// Registered 1-to-2 word demultiplexer: steers a tagged 7-bit stream into
// lanes A/B and presents each completed pair with valid/ready handshakes.
module demux7to14 #(
  parameter int unsigned W  = 7,
  parameter int unsigned CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  input  logic          in_sel,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_a,
  output logic [W-1:0]  out_b,
  output logic [CW-1:0] pair_cnt,
  output logic          dup_stall
);

  typedef enum logic [1:0] {EMPTY, GOT_A, GOT_B, FULL} state_t;

  state_t state_q, state_d;
  logic   in_acc, out_acc;

  assign in_acc  = in_valid & in_ready;
  assign out_acc = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  // In GOT_A/GOT_B an accept implies the opposite lane, so it always completes the pair.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY:        if (in_acc) state_d = in_sel ? GOT_B : GOT_A;
      GOT_A, GOT_B: if (in_acc) state_d = FULL;
      FULL: begin
        if (out_acc) begin
          if (in_acc) state_d = in_sel ? GOT_B : GOT_A;
          else        state_d = EMPTY;
        end
      end
      default:      state_d = EMPTY;
    endcase
  end

  always_comb begin
    out_valid = (state_q == FULL);
    in_ready  = 1'b1;
    if (!rst) begin
      unique case (state_q)
        EMPTY:   in_ready = 1'b1;
        GOT_A:   in_ready = in_sel;
        GOT_B:   in_ready = ~in_sel;
        FULL:    in_ready = out_ready;
        default: in_ready = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_a     <= '0;
      out_b     <= '0;
      pair_cnt  <= '0;
      dup_stall <= 1'b0;
    end else begin
      if (in_acc && !in_sel) out_a <= in_data;
      if (in_acc &&  in_sel) out_b <= in_data;
      if (out_acc)           pair_cnt <= pair_cnt + CW'(1);
      dup_stall <= in_valid & ~in_ready;
    end
  end

endmodule

// File: tb/tb_demux7to14.sv
// Directed bench for demux7to14: expected pairs are queued as stimulus is
// driven and matched against each delivered pair.
module tb_demux7to14;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [6:0] in_data = '0;
  logic       in_sel = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [6:0] out_a, out_b;
  logic [7:0] pair_cnt;
  logic       dup_stall;

  int         checks = 0;
  int         errors = 0;
  logic [13:0] sb_q[$];
  logic [7:0] exp_cnt;
  time        t0;

  demux7to14 #(.W(7), .CW(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel), .out_valid(out_valid),
    .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
    .pair_cnt(pair_cnt), .dup_stall(dup_stall)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Delivery monitor: any output accept must match the oldest queued pair.
  always @(negedge clk) begin
    if (out_valid && out_ready && !rst) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_pair", {2'b0, out_a, out_b}, 16'hFFFF);
      end else begin
        logic [13:0] e;
        e = sb_q.pop_front();
        chk("pair", {2'b0, out_a, out_b}, {2'b0, e});
      end
    end
  end

  // Present one word and hold it until accepted; returns #1 after the accept edge.
  task automatic send(input logic s, input logic [6:0] d);
    int unsigned n = 0;
    in_valid = 1'b1; in_sel = s; in_data = d;
    #1;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 20) chk("send_timeout", 16'(n), 16'(0));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [6:0] a, input logic [6:0] b);
    sb_q.push_back({a, b});
    exp_cnt = exp_cnt + 8'd1;
  endtask

  initial begin
    exp_cnt = '0;
    // Reset, with a word presented that must not be captured
    rst = 1'b1; in_valid = 1'b1; in_sel = 1'b0; in_data = 7'h7F;
    #1; chk("in_ready_in_rst", 16'(in_ready), 16'(1));
    cyc(); cyc();
    in_valid = 1'b0; rst = 1'b0;
    chk("rst_out_valid", 16'(out_valid), 16'(0));
    chk("rst_out_a", 16'(out_a), 16'(0));
    chk("rst_out_b", 16'(out_b), 16'(0));
    chk("rst_pair_cnt", 16'(pair_cnt), 16'(0));
    chk("rst_dup_stall", 16'(dup_stall), 16'(0));

    // Scenario 1: A then B
    out_ready = 1'b1;
    push(7'h15, 7'h6A);
    send(1'b0, 7'h15);
    chk("s1_no_valid_after_a", 16'(out_valid), 16'(0));
    send(1'b1, 7'h6A);
    chk("s1_valid_latency", 16'(out_valid), 16'(1));
    cyc();
    chk("s1_empty", 16'(out_valid), 16'(0));
    chk("s1_cnt", 16'(pair_cnt), 16'(exp_cnt));

    // Scenario 2: B then A
    push(7'h7F, 7'h01);
    send(1'b1, 7'h01);
    send(1'b0, 7'h7F);
    chk("s2_valid_latency", 16'(out_valid), 16'(1));
    cyc();
    chk("s2_cnt", 16'(pair_cnt), 16'(exp_cnt));

    // Scenario 3: duplicate lane stalls without overwriting
    send(1'b0, 7'h11);
    in_valid = 1'b1; in_sel = 1'b0; in_data = 7'h22;
    for (int i = 0; i < 3; i++) begin
      #1; chk("dup_in_ready", 16'(in_ready), 16'(0));
      @(posedge clk); #1;
      chk("dup_stall_flag", 16'(dup_stall), 16'(1));
      chk("dup_out_a_held", 16'(out_a), 16'(7'h11));
    end
    push(7'h11, 7'h33);
    send(1'b1, 7'h33);
    chk("dup_pair_valid", 16'(out_valid), 16'(1));
    cyc();
    chk("dup_stall_clear", 16'(dup_stall), 16'(0));

    // Scenario 4: backpressure, then simultaneous deliver + load
    out_ready = 1'b0;
    push(7'h21, 7'h52);
    send(1'b0, 7'h21);
    send(1'b1, 7'h52);
    in_valid = 1'b1; in_sel = 1'b0; in_data = 7'h44;
    for (int i = 0; i < 4; i++) begin
      #1; chk("bp_in_ready", 16'(in_ready), 16'(0));
      @(posedge clk); #1;
      chk("bp_hold", {out_valid, 1'b0, out_a, out_b}, {1'b1, 1'b0, 7'h21, 7'h52});
    end
    out_ready = 1'b1;
    #1; chk("bp_release_ready", 16'(in_ready), 16'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_got_a_valid", 16'(out_valid), 16'(0));
    chk("bp_got_a_data", 16'(out_a), 16'(7'h44));
    push(7'h44, 7'h0C);
    send(1'b1, 7'h0C);
    cyc();
    chk("bp_cnt", 16'(pair_cnt), 16'(exp_cnt));

    // Scenario 6a: reset in GOT_A
    send(1'b0, 7'h05);
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("rstA_zero", {out_valid, pair_cnt, out_a}, 16'h0);
    chk("rstA_out_b", 16'(out_b), 16'(0));
    exp_cnt = '0;

    // Scenario 5: 300 alternating words, no bubbles
    t0 = $time;
    for (int i = 0; i < 150; i++) begin
      logic [6:0] a, b;
      a = 7'(i);
      b = 7'(i * 3 + 1);
      push(a, b);
      send(1'b0, a);
      send(1'b1, b);
    end
    chk("stream_cycles", 16'(($time - t0) / 10), 16'(300));
    chk("stream_no_stall", 16'(dup_stall), 16'(0));
    cyc();
    chk("stream_cnt_wrap", 16'(pair_cnt), 16'(150));

    // Scenario 6b: reset in FULL with out_ready high: no delivery
    send(1'b0, 7'h0A);
    send(1'b1, 7'h0B);
    rst = 1'b1; out_ready = 1'b1;
    cyc(); rst = 1'b0;
    chk("rstF_zero", {out_valid, pair_cnt, out_a}, 16'h0);
    chk("rstF_out_b", 16'(out_b), 16'(0));
    exp_cnt = '0;

    push(7'h15, 7'h6A);
    send(1'b0, 7'h15);
    send(1'b1, 7'h6A);
    chk("post_rst_valid", 16'(out_valid), 16'(1));
    cyc();
    chk("post_rst_cnt", 16'(pair_cnt), 16'(1));
    chk("sb_drained", 16'(sb_q.size()), 16'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
